vga_timing_gen: RTL and testbench

//  Parametrised VGA timing generator and output stage. Divides the system clock to a pixel tick,

---
 rtl/vga_pkg.sv | 42 ++++
 rtl/vga_delay_line.sv | 36 +++
 rtl/vga_timing_gen.sv | 151 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants: standard timing sets, colour widths and the sync bundle
// that travels through the fetch-latency delay line.
package vga_pkg;

    localparam int RGB_W = 4;
    localparam int PIX_W = 3 * RGB_W;

    // 800x600@60, 40 MHz pixel clock
    localparam int SVGA_H_VISIBLE = 800;
    localparam int SVGA_H_FRONT   = 40;
    localparam int SVGA_H_SYNC    = 128;
    localparam int SVGA_H_BACK    = 88;
    localparam int SVGA_V_VISIBLE = 600;
    localparam int SVGA_V_FRONT   = 1;
    localparam int SVGA_V_SYNC    = 4;
    localparam int SVGA_V_BACK    = 23;
    localparam int SVGA_HSYNC_POL = 1;
    localparam int SVGA_VSYNC_POL = 1;

    // 640x480@60, 25.175 MHz pixel clock
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_HSYNC_POL = 0;
    localparam int VGA_VSYNC_POL = 0;

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
    } sync_t;

    function automatic int span_total(input int vis, input int front, input int sync, input int back);
        return vis + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register used to align sync/blank with the pixel-fetch
// pipeline. DEPTH==0 degenerates to a plain wire.
module vga_delay_line #(
    parameter int W     = 3,
    parameter int DEPTH = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused;
            assign w_unused = clk ^ reset ^ i_en;
            assign o_q      = i_d;
        end else begin : g_shift
            logic [W-1:0] r_sr [DEPTH];

            // NOTE: every stage is reset so the first PIPE_DELAY output pixels are blank, not garbage.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
                end else if (i_en) begin
                    r_sr[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
                end
            end

            assign o_q = r_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-tick divider, h/v counters, sync/blank decode
// delayed to match the fetch pipeline, and a registered RGB output stage.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV    = 6,
    parameter int H_VISIBLE  = SVGA_H_VISIBLE,
    parameter int H_FRONT    = SVGA_H_FRONT,
    parameter int H_SYNC     = SVGA_H_SYNC,
    parameter int H_BACK     = SVGA_H_BACK,
    parameter int V_VISIBLE  = SVGA_V_VISIBLE,
    parameter int V_FRONT    = SVGA_V_FRONT,
    parameter int V_SYNC     = SVGA_V_SYNC,
    parameter int V_BACK     = SVGA_V_BACK,
    parameter int HSYNC_POL  = SVGA_HSYNC_POL,
    parameter int VSYNC_POL  = SVGA_VSYNC_POL,
    parameter int CNT_W      = 11,
    parameter int PIPE_DELAY = 0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             pix_tick,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             line_start,
    output logic             frame_start,
    input  logic [PIX_W-1:0] pixel_in,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic [RGB_W-1:0] red,
    output logic [RGB_W-1:0] green,
    output logic [RGB_W-1:0] blue
);

    localparam int H_TOTAL = span_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = span_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EW      = CNT_W + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [EW-1:0]    H_VIS_E  = EW'(H_VISIBLE);
    localparam logic [EW-1:0]    V_VIS_E  = EW'(V_VISIBLE);
    localparam logic [EW-1:0]    HS_BEG   = EW'(H_VISIBLE + H_FRONT);
    localparam logic [EW-1:0]    HS_END   = EW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [EW-1:0]    VS_BEG   = EW'(V_VISIBLE + V_FRONT);
    localparam logic [EW-1:0]    VS_END   = EW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic             HS_ACT   = (HSYNC_POL != 0);
    localparam logic             VS_ACT   = (VSYNC_POL != 0);

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("CLK_DIV must be >= 1");
        end
        if (H_VISIBLE <= 0 || H_FRONT <= 0 || H_SYNC <= 0 || H_BACK <= 0 ||
            V_VISIBLE <= 0 || V_FRONT <= 0 || V_SYNC <= 0 || V_BACK <= 0) begin : g_bad_span
            $error("all visible/porch/sync spans must be > 0");
        end
        if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W) begin : g_bad_width
            $error("H_TOTAL/V_TOTAL do not fit in CNT_W bits");
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_delay
            $error("PIPE_DELAY must be in 0..15");
        end
    endgenerate

    logic [DIV_W-1:0] r_div;
    logic             r_pix_tick;
    logic [CNT_W-1:0] r_hcount;
    logic [CNT_W-1:0] r_vcount;
    logic             r_active;
    logic             r_hsync;
    logic             r_vsync;
    logic [PIX_W-1:0] r_rgb;
    logic [EW-1:0]    w_h_ext;
    logic [EW-1:0]    w_v_ext;
    sync_t            w_sync_in;
    sync_t            w_sync_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div      <= '0;
            r_pix_tick <= 1'b0;
        end else begin
            r_pix_tick <= (r_div == DIV_LAST);
            r_div      <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (r_pix_tick) begin
            if (r_hcount == H_LAST) begin
                r_hcount <= '0;
                r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
            end else begin
                r_hcount <= r_hcount + 1'b1;
            end
        end
    end

    // One extra bit keeps the end-of-sync compares from wrapping when a total hits 2**CNT_W.
    assign w_h_ext       = {1'b0, r_hcount};
    assign w_v_ext       = {1'b0, r_vcount};
    assign w_sync_in.vis = (w_h_ext < H_VIS_E) && (w_v_ext < V_VIS_E);
    assign w_sync_in.hs  = (w_h_ext >= HS_BEG) && (w_h_ext < HS_END);
    assign w_sync_in.vs  = (w_v_ext >= VS_BEG) && (w_v_ext < VS_END);

    vga_delay_line #(
        .W     (3),
        .DEPTH (PIPE_DELAY)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .i_en  (r_pix_tick),
        .i_d   (w_sync_in),
        .o_q   (w_sync_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= 1'b0;
            r_hsync  <= ~HS_ACT;
            r_vsync  <= ~VS_ACT;
            r_rgb    <= '0;
        end else if (r_pix_tick) begin
            r_active <= w_sync_d.vis;
            r_hsync  <= w_sync_d.hs ^ ~HS_ACT;
            r_vsync  <= w_sync_d.vs ^ ~VS_ACT;
            r_rgb    <= w_sync_d.vis ? pixel_in : '0;
        end
    end

    assign pix_tick    = r_pix_tick;
    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign line_start  = r_pix_tick && (r_hcount == '0);
    assign frame_start = r_pix_tick && (r_hcount == '0) && (r_vcount == '0);
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign active      = r_active;
    assign red         = r_rgb[2*RGB_W +: RGB_W];
    assign green       = r_rgb[RGB_W +: RGB_W];
    assign blue        = r_rgb[0 +: RGB_W];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (800x600 defaults, 640x480 at one clk per
// pixel, and a tiny frame with a 3-tick fetch delay) compared every clk against a model
// that derives all outputs from the absolute pixel-tick index since reset.
module tb_vga_timing_gen;
    import vga_pkg::*;

    typedef struct packed {
        logic        tick;
        logic        ls;
        logic        fs;
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        act;
        logic [11:0] rgb;
    } obs_t;

    typedef struct {
        int div;
        int hv, hf, hsn, hb;
        int vv, vf, vsn, vb;
        int hpol, vpol, dly, mode;
    } cfg_t;

    localparam int C_DIV = 2;
    localparam int C_HV = 12, C_HF = 2, C_HS = 3, C_HB = 2;
    localparam int C_VV = 6,  C_VF = 1, C_VS = 2, C_VB = 2;
    localparam int C_DLY = 3;

    logic clk = 1'b0;
    logic reset;
    int   n;
    int   clk_idx;
    int   n_checks = 0;
    int   n_fail = 0;
    int unsigned seed;
    cfg_t cfg_a, cfg_b, cfg_c;

    logic        a_tick, a_ls, a_fs, a_hs, a_vs, a_act;
    logic [10:0] a_h, a_v;
    logic [3:0]  a_r, a_g, a_b;
    logic [11:0] a_pix;
    logic        b_tick, b_ls, b_fs, b_hs, b_vs, b_act;
    logic [10:0] b_h, b_v;
    logic [3:0]  b_r, b_g, b_b;
    logic [11:0] b_pix;
    logic        c_tick, c_ls, c_fs, c_hs, c_vs, c_act;
    logic [4:0]  c_h, c_v;
    logic [3:0]  c_r, c_g, c_b;
    logic [11:0] c_pix;

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    vga_timing_gen u_a (
        .clk(clk), .reset(reset), .pix_tick(a_tick), .hcount(a_h), .vcount(a_v),
        .line_start(a_ls), .frame_start(a_fs), .pixel_in(a_pix), .hsync(a_hs), .vsync(a_vs),
        .active(a_act), .red(a_r), .green(a_g), .blue(a_b)
    );

    vga_timing_gen #(
        .CLK_DIV(1),
        .H_VISIBLE(VGA_H_VISIBLE), .H_FRONT(VGA_H_FRONT), .H_SYNC(VGA_H_SYNC), .H_BACK(VGA_H_BACK),
        .V_VISIBLE(VGA_V_VISIBLE), .V_FRONT(VGA_V_FRONT), .V_SYNC(VGA_V_SYNC), .V_BACK(VGA_V_BACK),
        .HSYNC_POL(VGA_HSYNC_POL), .VSYNC_POL(VGA_VSYNC_POL), .CNT_W(11), .PIPE_DELAY(0)
    ) u_b (
        .clk(clk), .reset(reset), .pix_tick(b_tick), .hcount(b_h), .vcount(b_v),
        .line_start(b_ls), .frame_start(b_fs), .pixel_in(b_pix), .hsync(b_hs), .vsync(b_vs),
        .active(b_act), .red(b_r), .green(b_g), .blue(b_b)
    );

    vga_timing_gen #(
        .CLK_DIV(C_DIV),
        .H_VISIBLE(C_HV), .H_FRONT(C_HF), .H_SYNC(C_HS), .H_BACK(C_HB),
        .V_VISIBLE(C_VV), .V_FRONT(C_VF), .V_SYNC(C_VS), .V_BACK(C_VB),
        .HSYNC_POL(1), .VSYNC_POL(1), .CNT_W(5), .PIPE_DELAY(C_DLY)
    ) u_c (
        .clk(clk), .reset(reset), .pix_tick(c_tick), .hcount(c_h), .vcount(c_v),
        .line_start(c_ls), .frame_start(c_fs), .pixel_in(c_pix), .hsync(c_hs), .vsync(c_vs),
        .active(c_act), .red(c_r), .green(c_g), .blue(c_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h clk=%0d", tag, got, exp, clk_idx);
        end
    endtask

    function automatic int h_total(input cfg_t c);
        return c.hv + c.hf + c.hsn + c.hb;
    endfunction

    function automatic int v_total(input cfg_t c);
        return c.vv + c.vf + c.vsn + c.vb;
    endfunction

    // Pixel ticks consumed by the counters after k clk edges since reset release.
    function automatic int ticks_after(input cfg_t c, input int k);
        return (k == 0) ? 0 : (k - 1) / c.div;
    endfunction

    // Colour the fetch pipeline returns for absolute screen position q.
    function automatic logic [11:0] pix_fn(input cfg_t c, input int q);
        case (c.mode)
            0:       return 12'((q * 40503) ^ int'(seed) ^ (q >>> 3));
            1:       return 12'h61F;
            default: return 12'(q % h_total(c));
        endcase
    endfunction

    function automatic obs_t model(input cfg_t c, input int k);
        obs_t o;
        int   ht, vt, p, q, qh, qv;
        logic vis, hs, vs;
        ht = h_total(c);
        vt = v_total(c);
        o  = '0;
        p  = ticks_after(c, k);
        o.tick = (k > 0) && (k % c.div == 0);
        o.h    = 11'(p % ht);
        o.v    = 11'((p / ht) % vt);
        o.ls   = o.tick && (p % ht == 0);
        o.fs   = o.ls && ((p / ht) % vt == 0);
        q   = p - 1 - c.dly;
        vis = 1'b0;
        hs  = 1'b0;
        vs  = 1'b0;
        if (q >= 0) begin
            qh  = q % ht;
            qv  = (q / ht) % vt;
            vis = (qh < c.hv) && (qv < c.vv);
            hs  = (qh >= c.hv + c.hf) && (qh < c.hv + c.hf + c.hsn);
            vs  = (qv >= c.vv + c.vf) && (qv < c.vv + c.vf + c.vsn);
        end
        o.hs  = hs ? (c.hpol != 0) : (c.hpol == 0);
        o.vs  = vs ? (c.vpol != 0) : (c.vpol == 0);
        o.act = vis;
        o.rgb = vis ? pix_fn(c, q) : 12'h000;
        return o;
    endfunction

    int a_last = -1, a_hcnt = 0, b_hcnt = 0;
    bit a_seen = 0, b_seen = 0;

    task automatic compare_all();
        obs_t oa, ob, oc;
        oa = '{a_tick, a_ls, a_fs, a_h, a_v, a_hs, a_vs, a_act, {a_r, a_g, a_b}};
        ob = '{b_tick, b_ls, b_fs, b_h, b_v, b_hs, b_vs, b_act, {b_r, b_g, b_b}};
        oc = '{c_tick, c_ls, c_fs, {6'b0, c_h}, {6'b0, c_v}, c_hs, c_vs, c_act, {c_r, c_g, c_b}};
        check("svga_outputs", 64'(oa), 64'(model(cfg_a, n)));
        check("vga640_outputs", 64'(ob), 64'(model(cfg_b, n)));
        check("tiny_dly3_outputs", 64'(oc), 64'(model(cfg_c, n)));
        if (reset) begin
            a_last = -1;
            a_seen = 0;
            b_seen = 0;
        end
        if (a_tick) begin
            if (a_last >= 0) check("svga_tick_period", 64'(clk_idx - a_last), 64'(6));
            a_last = clk_idx;
            if (a_ls) begin
                if (a_seen) check("svga_hsync_ticks", 64'(a_hcnt), 64'(128));
                a_seen = 1;
                a_hcnt = 0;
            end
            if (a_hs) a_hcnt++;
        end
        if (b_tick) begin
            if (b_ls) begin
                if (b_seen) check("vga640_hsync_low_ticks", 64'(b_hcnt), 64'(96));
                b_seen = 1;
                b_hcnt = 0;
            end
            if (!b_hs) b_hcnt++;
        end
    endtask

    // Present the colour for the position the counters show now, as a fetch pipeline would.
    task automatic drive_pix();
        int pa, pb, pc;
        pa = ticks_after(cfg_a, n) - cfg_a.dly;
        pb = ticks_after(cfg_b, n) - cfg_b.dly;
        pc = ticks_after(cfg_c, n) - cfg_c.dly;
        a_pix = (pa >= 0 && !reset) ? pix_fn(cfg_a, pa) : 12'($urandom);
        b_pix = (pb >= 0 && !reset) ? pix_fn(cfg_b, pb) : 12'($urandom);
        c_pix = (pc >= 0 && !reset) ? pix_fn(cfg_c, pc) : 12'($urandom);
    endtask

    task automatic step();
        @(negedge clk);
        clk_idx++;
        compare_all();
        drive_pix();
    endtask

    initial begin
        int rst_at, wait_cnt;
        reset   = 1'b1;
        clk_idx = 0;
        seed    = $urandom;
        a_pix   = '0;
        b_pix   = '0;
        c_pix   = '0;
        cfg_a = '{6, SVGA_H_VISIBLE, SVGA_H_FRONT, SVGA_H_SYNC, SVGA_H_BACK,
                  SVGA_V_VISIBLE, SVGA_V_FRONT, SVGA_V_SYNC, SVGA_V_BACK,
                  1, 1, 0, 0};
        cfg_b = '{1, VGA_H_VISIBLE, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK,
                  VGA_V_VISIBLE, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK,
                  0, 0, 0, 1};
        cfg_c = '{C_DIV, C_HV, C_HF, C_HS, C_HB, C_VV, C_VF, C_VS, C_VB, 1, 1, C_DLY, 2};

        repeat (3) step();
        #1 reset = 1'b0;

        rst_at = 7000 + int'($urandom_range(0, 1500));
        repeat (rst_at) step();

        // Mid-line reset: outputs must drop to reset values without waiting for a clk edge.
        #1 reset = 1'b1;
        #1 compare_all();
        repeat (3) step();
        #1 reset = 1'b0;

        wait_cnt = 0;
        do begin
            step();
            wait_cnt++;
        end while (!a_tick && wait_cnt < 20);
        check("svga_first_tick_after_reset", 64'(wait_cnt), 64'(6));

        repeat (5500) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
